rx_word_packer: RTL and testbench
=================================

RX_WORD_PACKER -- requirements
Module: rx_word_packer

Interface
REQ-001 SHALL have parameter BYTES, default 4, output word width in bytes; legal values 2, 4, 8.
REQ-002 SHALL have parameter STRIP_PRE, default 1; 1 = strip preamble/SFD, 0 = pass every byte while gmii_den high.
REQ-003 SHALL have parameter MODW, default $clog2(BYTES), width of out_mod.
REQ-004 SHALL have port clk  in  1  single clock, used for all logic.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port giga_mode  in  1  1 = byte per cycle; 0 = nibble per cycle on gmii_din[3:0], low nibble first.
REQ-007 SHALL have port gmii_den  in  1  receive data valid.
REQ-008 SHALL have port gmii_din  in  8  receive data.
REQ-009 SHALL have port gmii_err  in  1  receive error.
REQ-010 SHALL have port out_data  out  8*BYTES  packed word; first byte in the MSB lane.
REQ-011 SHALL have port out_valid  out  1  word strobe, one cycle per word.
REQ-012 SHALL have port out_sop  out  1  first word of frame.
REQ-013 SHALL have port out_eop  out  1  last word of frame.
REQ-014 SHALL have port out_mod  out  MODW  unused lanes in eop word, 0 = full; 0 when out_eop is low.
REQ-015 SHALL have port out_err  out  1  frame error; valid with out_eop only.
REQ-016 SHALL have port out_len  out  16  frame byte count, valid with out_eop, saturating at 16'hFFFF.
REQ-017 SHALL have port frame_cnt  out  32  frames emitted, wrapping.
REQ-018 SHALL have port err_cnt  out  32  frames emitted with out_err=1, wrapping.

Function
REQ-019 SHALL implement states IDLE, PRE, DATA, DROP.
REQ-020 IDLE->PRE on gmii_den=1 when STRIP_PRE=1; IDLE->DATA when STRIP_PRE=0, with that byte as data.
REQ-021 PRE->DATA on assembled byte 8'hD5; PRE->IDLE on gmii_den=0, with no output; PRE->DROP on gmii_err=1.
REQ-022 DROP SHALL produce no output and SHALL return to IDLE on gmii_den=0.
REQ-023 DATA->IDLE on gmii_den=0, flushing the pending/partial word in that same cycle.
REQ-024 giga_mode SHALL be sampled only on the IDLE exit cycle and held for the rest of the frame; mid-frame changes are ignored.
REQ-025 Nibble mode: two gmii_den cycles form one byte as {second[3:0], first[3:0]}.
REQ-026 Nibble mode: an odd nibble at gmii_den fall SHALL be discarded and SHALL set the frame error.
REQ-027 Bytes fill lanes MSB-first.
REQ-028 A completed word SHALL be held and emitted in the cycle the next data byte arrives (not eop), or in the cycle gmii_den falls (eop, mod=0).
REQ-029 A partial word at gmii_den fall SHALL be emitted with out_eop=1, out_mod = BYTES - fill, unused lanes zero.
REQ-030 At most one word SHALL be emitted per cycle.
REQ-031 out_sop SHALL be asserted on the first emitted word of a frame; a single-word frame SHALL assert out_sop and out_eop together.
REQ-032 A DATA frame with zero bytes SHALL produce no output and SHALL not increment any counter.
REQ-033 gmii_err=1 in any DATA cycle SHALL set a sticky frame error, reported as out_err with out_eop.
REQ-034 out_len SHALL count data bytes only, excluding preamble/SFD and any discarded nibble.
REQ-035 frame_cnt SHALL increment on every out_eop; err_cnt SHALL increment on out_eop when out_err=1.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 While rst=1, all outputs and counters SHALL be 0 and state SHALL be IDLE.
REQ-038 Reset mid-frame SHALL discard the partial frame with no eop emitted.
REQ-039 After rst falls while gmii_den=1, the block SHALL stay in DROP until gmii_den=0.

Verification
REQ-040 BYTES=4, giga, 7x55+D5+bytes 01..0A, den falls -> words 01020304 (sop), 05060708, 090A0000 (eop, mod=2, len=10); frame_cnt=1.
REQ-041 BYTES=4, 8 data bytes 11..18 -> word 11121314 then 15161718 with eop, mod=0, emitted in the den-fall cycle.
REQ-042 BYTES=2, nibble mode, 3 data bytes plus one extra nibble -> 3 bytes emitted, eop mod=1, out_err=1, err_cnt=1.
REQ-043 gmii_err pulse in the preamble -> no output, counters unchanged; gmii_err in DATA -> out_err=1 on eop.
REQ-044 BYTES=8, STRIP_PRE=0, 3-byte burst AA BB CC -> one word AABBCC0000000000 with sop=eop=1, mod=5, len=3.
REQ-045 rst asserted after 5 data bytes -> no eop emitted, all outputs 0; next clean frame packs correctly from lane 0.

Source files
------------

// File: rtl/rx_word_packer.sv
// rtl/rx_word_packer.sv - GMII/MII receive byte stream packed into BYTES-wide words.
// Strips preamble/SFD, tracks frame length and error, emits sop/eop/mod-tagged words.
module rx_word_packer #(
   parameter int BYTES     = 4,
   parameter int STRIP_PRE = 1,
   parameter int MODW      = $clog2(BYTES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 giga_mode,
   input  logic                 gmii_den,
   input  logic [7:0]           gmii_din,
   input  logic                 gmii_err,
   output logic [8*BYTES-1:0]   out_data,
   output logic                 out_valid,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [MODW-1:0]      out_mod,
   output logic                 out_err,
   output logic [15:0]          out_len,
   output logic [31:0]          frame_cnt,
   output logic [31:0]          err_cnt
);

   localparam int             FW   = $clog2(BYTES + 1);
   localparam logic [FW-1:0]  FULL = FW'(BYTES);
   localparam logic [7:0]     SFD  = 8'hD5;

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_after_rst;
   logic                 r_giga;
   logic                 r_phase;
   logic [3:0]           r_nib_lo;
   logic [8*BYTES-1:0]   r_word;
   logic [FW-1:0]        r_fill;
   logic [15:0]          r_len;
   logic                 r_err;
   logic                 r_sop_pend;

   logic                 w_giga;
   logic                 w_byte_ok;
   logic [7:0]           w_byte;
   logic                 w_ingest;
   logic                 w_byte_in;
   logic                 w_flush;
   logic                 w_emit_mid;
   logic                 w_emit_eop;
   logic                 w_frame_err;
   logic [MODW-1:0]      w_mod;

   // giga_mode is followed while idle and frozen once a frame starts
   assign w_giga    = (r_state == S_IDLE) ? giga_mode : r_giga;
   assign w_byte_ok = w_giga | r_phase;
   assign w_byte    = w_giga ? gmii_din : {gmii_din[3:0], r_nib_lo};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (gmii_den) begin
               if (r_after_rst)         w_next = S_DROP;
               else if (STRIP_PRE != 0) w_next = S_PRE;
               else                     w_next = S_DATA;
            end
         end
         S_PRE: begin
            if (!gmii_den)                         w_next = S_IDLE;
            else if (gmii_err)                     w_next = S_DROP;
            else if (w_byte_ok && w_byte == SFD)   w_next = S_DATA;
         end
         S_DATA:  if (!gmii_den) w_next = S_IDLE;
         S_DROP:  if (!gmii_den) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ingest    = gmii_den && ((r_state == S_DATA) ||
                    (r_state == S_IDLE && STRIP_PRE == 0 && !r_after_rst));
      w_byte_in   = w_ingest && w_byte_ok;
      w_flush     = (r_state == S_DATA) && !gmii_den;
      w_emit_mid  = w_byte_in && (r_fill == FULL);
      w_emit_eop  = w_flush && (r_fill != '0);
      w_frame_err = r_err | r_phase;
      w_mod       = w_emit_eop ? MODW'(FULL - r_fill) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_after_rst <= 1'b1;
         r_giga      <= 1'b1;
         r_phase     <= 1'b0;
         r_nib_lo    <= '0;
         r_word      <= '0;
         r_fill      <= '0;
         r_len       <= '0;
         r_err       <= 1'b0;
         r_sop_pend  <= 1'b1;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_mod     <= '0;
         out_err     <= 1'b0;
         out_len     <= '0;
         frame_cnt   <= '0;
         err_cnt     <= '0;
      end else begin
         r_after_rst <= 1'b0;
         if (r_state == S_IDLE) r_giga <= giga_mode;

         if (!gmii_den) begin
            r_phase <= 1'b0;
         end else if (!w_giga) begin
            r_phase  <= ~r_phase;
            r_nib_lo <= gmii_din[3:0];
         end

         if (w_ingest && gmii_err) r_err <= 1'b1;

         if (w_flush) begin
            r_word     <= '0;
            r_fill     <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_sop_pend <= 1'b1;
         end else if (w_byte_in) begin
            if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
            // a full word stays held until the next byte proves it is not the last
            if (r_fill == FULL) begin
               r_word <= {w_byte, {(8*(BYTES-1)){1'b0}}};
               r_fill <= FW'(1);
            end else begin
               for (int i = 0; i < BYTES; i++)
                  if (r_fill == FW'(i)) r_word[8*(BYTES-1-i) +: 8] <= w_byte;
               r_fill <= r_fill + FW'(1);
            end
            if (w_emit_mid) r_sop_pend <= 1'b0;
         end

         out_valid <= w_emit_mid | w_emit_eop;
         out_data  <= (w_emit_mid | w_emit_eop) ? r_word : '0;
         out_sop   <= (w_emit_mid | w_emit_eop) & r_sop_pend;
         out_eop   <= w_emit_eop;
         out_mod   <= w_mod;
         out_err   <= w_emit_eop & w_frame_err;
         out_len   <= w_emit_eop ? r_len : 16'd0;
         if (w_emit_eop) begin
            frame_cnt <= frame_cnt + 32'd1;
            if (w_frame_err) err_cnt <= err_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_rx_word_packer.sv
// tb/tb_rx_word_packer.sv - scoreboard bench for rx_word_packer in three configurations.
module tb_rx_word_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       giga;
   logic       den;
   logic       err;
   logic [7:0] din;
   int         sel;

   always #5 clk = ~clk;

   logic den4, den2, den8;
   assign den4 = den && (sel == 4);
   assign den2 = den && (sel == 2);
   assign den8 = den && (sel == 8);

   logic [31:0] o4_data;  logic o4_valid, o4_sop, o4_eop, o4_err;
   logic [1:0]  o4_mod;   logic [15:0] o4_len; logic [31:0] o4_fc, o4_ec;
   logic [15:0] o2_data;  logic o2_valid, o2_sop, o2_eop, o2_err;
   logic [0:0]  o2_mod;   logic [15:0] o2_len; logic [31:0] o2_fc, o2_ec;
   logic [63:0] o8_data;  logic o8_valid, o8_sop, o8_eop, o8_err;
   logic [2:0]  o8_mod;   logic [15:0] o8_len; logic [31:0] o8_fc, o8_ec;

   rx_word_packer #(.BYTES(4), .STRIP_PRE(1)) u4 (
      .clk(clk), .rst(rst), .giga_mode(giga), .gmii_den(den4), .gmii_din(din), .gmii_err(err),
      .out_data(o4_data), .out_valid(o4_valid), .out_sop(o4_sop), .out_eop(o4_eop),
      .out_mod(o4_mod), .out_err(o4_err), .out_len(o4_len), .frame_cnt(o4_fc), .err_cnt(o4_ec));

   rx_word_packer #(.BYTES(2), .STRIP_PRE(1)) u2 (
      .clk(clk), .rst(rst), .giga_mode(giga), .gmii_den(den2), .gmii_din(din), .gmii_err(err),
      .out_data(o2_data), .out_valid(o2_valid), .out_sop(o2_sop), .out_eop(o2_eop),
      .out_mod(o2_mod), .out_err(o2_err), .out_len(o2_len), .frame_cnt(o2_fc), .err_cnt(o2_ec));

   rx_word_packer #(.BYTES(8), .STRIP_PRE(0)) u8 (
      .clk(clk), .rst(rst), .giga_mode(giga), .gmii_den(den8), .gmii_din(din), .gmii_err(err),
      .out_data(o8_data), .out_valid(o8_valid), .out_sop(o8_sop), .out_eop(o8_eop),
      .out_mod(o8_mod), .out_err(o8_err), .out_len(o8_len), .frame_cnt(o8_fc), .err_cnt(o8_ec));

   typedef struct {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
      logic [15:0] len;
   } exp_t;

   exp_t q4[$];
   exp_t q2[$];
   exp_t q8[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // reference packing: data bytes left-aligned MSB-first into s-byte words
   function automatic void push(input int s, input logic [7:0] b[$], input logic e);
      int n = b.size();
      for (int i = 0; i < n; i += s) begin
         exp_t x;
         x.d = '0;
         for (int j = 0; j < s; j++)
            if (i + j < n) x.d[63-8*j -: 8] = b[i+j];
         x.sop = (i == 0);
         x.eop = (i + s >= n);
         x.mod = x.eop ? 3'(i + s - n) : 3'd0;
         x.err = x.eop & e;
         x.len = x.eop ? 16'(n) : 16'd0;
         if (s == 4)      q4.push_back(x);
         else if (s == 2) q2.push_back(x);
         else             q8.push_back(x);
      end
   endfunction

   task automatic mon(input int s, input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] mod, input logic er, input logic [15:0] len);
      exp_t  x;
      int    sz;
      string t;
      t  = $sformatf("w%0d", s);
      sz = (s == 4) ? q4.size() : (s == 2) ? q2.size() : q8.size();
      check({t, "_expected_pending"}, 64'(sz != 0), 64'd1);
      if (sz != 0) begin
         if (s == 4)      x = q4.pop_front();
         else if (s == 2) x = q2.pop_front();
         else             x = q8.pop_front();
         check({t, "_data"}, d, x.d);
         check({t, "_sop"}, 64'(sop), 64'(x.sop));
         check({t, "_eop"}, 64'(eop), 64'(x.eop));
         check({t, "_mod"}, 64'(mod), 64'(x.mod));
         if (x.eop) begin
            check({t, "_err"}, 64'(er), 64'(x.err));
            check({t, "_len"}, 64'(len), 64'(x.len));
         end
      end
   endtask

   always @(negedge clk) begin
      if (o4_valid) mon(4, {o4_data, 32'h0}, o4_sop, o4_eop, {1'b0, o4_mod}, o4_err, o4_len);
      if (o2_valid) mon(2, {o2_data, 48'h0}, o2_sop, o2_eop, {2'b0, o2_mod}, o2_err, o2_len);
      if (o8_valid) mon(8, o8_data, o8_sop, o8_eop, o8_mod, o8_err, o8_len);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e);
      den = 1'b1; din = b; err = e;
      tick();
   endtask

   task automatic send_nib(input logic [3:0] n);
      den = 1'b1; din = {4'h0, n}; err = 1'b0;
      tick();
   endtask

   task automatic idle(input int n);
      den = 1'b0; din = 8'h00; err = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pre_giga();
      repeat (7) send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
   endtask

   task automatic pre_nib();
      repeat (15) send_nib(4'h5);
      send_nib(4'hD);
   endtask

   initial begin
      logic [7:0] b[$];
      rst = 1'b1; den = 1'b0; err = 1'b0; din = 8'h00; giga = 1'b1; sel = 4;
      repeat (3) tick();
      check("rst_valid4", 64'(o4_valid), 64'd0);
      check("rst_data4", 64'(o4_data), 64'd0);
      check("rst_eop4", 64'(o4_eop), 64'd0);
      check("rst_fc4", 64'(o4_fc), 64'd0);
      check("rst_ec4", 64'(o4_ec), 64'd0);
      check("rst_valid8", 64'(o8_valid), 64'd0);
      check("rst_fc2", 64'(o2_fc), 64'd0);
      rst = 1'b0;
      idle(3);

      // giga frame with partial last word
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      push(4, b, 1'b0);
      pre_giga();
      foreach (b[i]) send_byte(b[i], 1'b0);
      idle(4);
      check("fc4_after_f1", 64'(o4_fc), 64'd1);

      // exact multiple: eop in the den-fall cycle; mid-frame giga change ignored
      b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
      push(4, b, 1'b0);
      pre_giga();
      foreach (b[i]) begin
         send_byte(b[i], 1'b0);
         if (i == 1) giga = 1'b0;
      end
      den = 1'b0; din = 8'h00;
      tick();
      check("eop_at_den_fall", 64'(o4_valid & o4_eop), 64'd1);
      giga = 1'b1;
      idle(3);
      check("fc4_after_f2", 64'(o4_fc), 64'd2);

      // error during preamble drops the whole frame
      send_byte(8'h55, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h55, 1'b1);
      repeat (4) send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
      repeat (3) send_byte(8'h77, 1'b0);
      idle(3);
      check("fc4_pre_err", 64'(o4_fc), 64'd2);
      check("ec4_pre_err", 64'(o4_ec), 64'd0);

      // error during data flagged on eop
      b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
      push(4, b, 1'b1);
      pre_giga();
      foreach (b[i]) send_byte(b[i], i == 2);
      idle(3);
      check("fc4_data_err", 64'(o4_fc), 64'd3);
      check("ec4_data_err", 64'(o4_ec), 64'd1);

      // zero-byte data frame
      pre_giga();
      idle(3);
      check("fc4_empty", 64'(o4_fc), 64'd3);

      // nibble mode with a trailing odd nibble
      sel = 2; giga = 1'b0;
      idle(1);
      b = '{8'h12, 8'h34, 8'h56};
      push(2, b, 1'b1);
      pre_nib();
      foreach (b[i]) begin
         send_nib(b[i][3:0]);
         send_nib(b[i][7:4]);
      end
      send_nib(4'h7);
      idle(3);
      check("fc2_nib", 64'(o2_fc), 64'd1);
      check("ec2_nib", 64'(o2_ec), 64'd1);
      giga = 1'b1;

      // no preamble stripping, 8-byte words
      sel = 8;
      idle(1);
      b = '{8'hAA, 8'hBB, 8'hCC};
      push(8, b, 1'b0);
      foreach (b[i]) send_byte(b[i], 1'b0);
      idle(3);
      b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
      push(8, b, 1'b0);
      foreach (b[i]) send_byte(b[i], 1'b0);
      idle(3);
      check("fc8", 64'(o8_fc), 64'd2);

      // reset mid-frame, released while den still high
      sel = 4;
      idle(1);
      pre_giga();
      for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0);
      rst = 1'b1; den = 1'b1; din = 8'h36;
      tick();
      check("midrst_valid", 64'(o4_valid), 64'd0);
      check("midrst_eop", 64'(o4_eop), 64'd0);
      check("midrst_fc", 64'(o4_fc), 64'd0);
      check("midrst_data", 64'(o4_data), 64'd0);
      tick();
      rst = 1'b0;
      send_byte(8'h37, 1'b0);
      send_byte(8'h38, 1'b0);
      idle(3);
      check("fc4_after_rst", 64'(o4_fc), 64'd0);
      b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      push(4, b, 1'b0);
      pre_giga();
      foreach (b[i]) send_byte(b[i], 1'b0);
      idle(4);
      check("fc4_clean", 64'(o4_fc), 64'd1);

      check("q4_drained", 64'(q4.size()), 64'd0);
      check("q2_drained", 64'(q2.size()), 64'd0);
      check("q8_drained", 64'(q8.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
